// File: rtl/uart_cmd_comm_if.sv
// uart_cmd_comm_if
// Core-side bundle of the UART command front end.
//   cmd[23:0]    assembled command word (first host byte in [23:16])
//   cmd_rdy      command valid, held until acknowledged
//   clr_cmd_rdy  single-cycle acknowledge from the core
//   resp_data    response byte to serialize
//   send_resp    single-cycle request to transmit resp_data
//   resp_sent    single-cycle pulse when the response byte has left TX
//
// Handshake semantics:
//   Command path: cmd_rdy acts as "valid". The core consumes cmd while cmd_rdy=1
//   and answers with a one-cycle clr_cmd_rdy pulse, which acts as "ready+ack".
//   cmd_rdy drops on the following cycle. Until then cmd is frozen and further
//   host bytes are dropped.
//   Response path: send_resp acts as "valid". It is taken only when the
//   transmitter is idle or in its resp_sent cycle. Otherwise it is ignored.
//   resp_sent marks the end of the stop bit, and the core may issue the next
//   send_resp in that same cycle.
interface uart_cmd_comm_if;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp_data;
  logic        send_resp;
  logic        resp_sent;

  // UART front end side
  modport slave (
    output cmd, cmd_rdy, resp_sent,
    input  clr_cmd_rdy, resp_data, send_resp
  );

  // Digital core side
  modport master (
    input  cmd, cmd_rdy, resp_sent,
    output clr_cmd_rdy, resp_data, send_resp
  );
endinterface

// File: rtl/uart_cmd_comm.sv
// uart_cmd_comm
// Host-side serial front end. It deserializes host UART bytes and assembles
// three of them into a 24-bit command word for the core. It also serializes
// the core's 8-bit response bytes back to the host.
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   RX            serial input from the host (asynchronous, idle high)
//   TX            serial output to the host (idle high)
//   core          uart_cmd_comm_if.slave: cmd/cmd_rdy/clr_cmd_rdy,
//                 resp_data/send_resp/resp_sent
//   rx_state_dbg  current receive FSM state
//   tx_state_dbg  current transmit FSM state
module uart_cmd_comm #(
  parameter int BAUD_DIV     = 868,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RX,
  output logic             TX,
  uart_cmd_comm_if.slave   core,
  output logic [1:0]       rx_state_dbg,
  output logic [1:0]       tx_state_dbg
);

  localparam int CW       = $clog2(BAUD_DIV + 1);
  localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int TW       = $clog2(TO_LIMIT + 1);

  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] BAUD_M1   = CW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TO_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // RX synchronizer
  // ---------------------------------------------------------------------------
  logic rx_s1, rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // RX deserializer
  // The baud counter is loaded with N and expires after N cycles, on the
  // cycle in which it reads 1. The first load is BAUD_DIV/2, so every later
  // sample falls at mid-bit.
  // ---------------------------------------------------------------------------
  state_t        rx_state, rx_state_nx;
  logic [CW-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]    rx_idx, rx_idx_nx;
  logic [7:0]    rx_shift, rx_shift_nx;
  logic          byte_vld, byte_vld_nx;
  logic          frame_err, frame_err_nx;
  logic          rx_expire;

  assign rx_expire = (rx_cnt == CW'(1));

  always_comb begin
    rx_state_nx  = rx_state;
    rx_cnt_nx    = (rx_cnt != '0) ? rx_cnt - CW'(1) : rx_cnt;
    rx_idx_nx    = rx_idx;
    rx_shift_nx  = rx_shift;
    byte_vld_nx  = 1'b0;
    frame_err_nx = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (!rx_s2) begin
          rx_state_nx = S_START;
          rx_cnt_nx   = BAUD_HALF;
        end
      end
      S_START: begin
        if (rx_expire) begin
          if (rx_s2) begin
            rx_state_nx = S_IDLE;  // start bit was only a glitch
          end else begin
            rx_state_nx = S_DATA;
            rx_cnt_nx   = BAUD_FULL;
            rx_idx_nx   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (rx_expire) begin
          rx_shift_nx = {rx_s2, rx_shift[7:1]};  // LSB arrives first
          rx_cnt_nx   = BAUD_FULL;
          if (rx_idx == 3'd7) rx_state_nx = S_STOP;
          else                rx_idx_nx   = rx_idx + 3'd1;
        end
      end
      S_STOP: begin
        if (rx_expire) begin
          rx_state_nx = S_IDLE;
          if (rx_s2) byte_vld_nx  = 1'b1;
          else       frame_err_nx = 1'b1;
        end
      end
      default: rx_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= 3'd0;
      rx_shift  <= 8'h00;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_state_nx;
      rx_cnt    <= rx_cnt_nx;
      rx_idx    <= rx_idx_nx;
      rx_shift  <= rx_shift_nx;
      byte_vld  <= byte_vld_nx;
      frame_err <= frame_err_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Command assembler with inter-byte timeout
  // rx_shift keeps the received byte while byte_vld is high, because the next
  // DATA state is at least half a bit away.
  // ---------------------------------------------------------------------------
  logic [23:0]   cmd_q;
  logic          cmd_rdy_q;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] idle_cnt;
  logic          timeout_hit;
  logic          cmd_set;

  assign timeout_hit = (idle_cnt == TO_MAX);
  assign cmd_set     = byte_vld && !cmd_rdy_q && (byte_cnt == 2'd2);

  // Idle time runs only while a command is partially assembled and the line
  // is quiet. It saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (rx_state != S_IDLE || byte_cnt == 2'd0) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TO_MAX) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q    <= 24'h000000;
      byte_cnt <= 2'd0;
    end else if (frame_err) begin
      byte_cnt <= 2'd0;
    end else if (byte_vld) begin
      // While cmd_rdy is high, the byte is dropped and the count stays put.
      if (!cmd_rdy_q) begin
        case (byte_cnt)
          2'd0:    begin cmd_q[23:16] <= rx_shift; byte_cnt <= 2'd1; end
          2'd1:    begin cmd_q[15:8]  <= rx_shift; byte_cnt <= 2'd2; end
          default: begin cmd_q[7:0]   <= rx_shift; byte_cnt <= 2'd0; end
        endcase
      end
    end else if (timeout_hit) begin
      byte_cnt <= 2'd0;
    end
  end

  // A set takes priority over a clear. The two can only coincide when
  // cmd_rdy is already low, so the clear has nothing to undo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cmd_rdy_q <= 1'b0;
    else if (cmd_set)          cmd_rdy_q <= 1'b1;
    else if (core.clr_cmd_rdy) cmd_rdy_q <= 1'b0;
  end

  assign core.cmd     = cmd_q;
  assign core.cmd_rdy = cmd_rdy_q;

  // ---------------------------------------------------------------------------
  // TX serializer
  // The counter loads BAUD_DIV-1 at each bit boundary, and the bit ends on
  // the cycle it reads 0. The last stop-bit cycle is also the resp_sent cycle
  // and accepts a new request, so frames can run back to back.
  // ---------------------------------------------------------------------------
  state_t        tx_state, tx_state_nx;
  logic [CW-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]    tx_idx, tx_idx_nx;
  logic [7:0]    tx_shift, tx_shift_nx;
  logic          tx_q, tx_nx;
  logic          tx_bit_end;
  logic          tx_done;
  logic          tx_accept;

  assign tx_bit_end = (tx_cnt == '0);
  assign tx_done    = (tx_state == S_STOP) && tx_bit_end;
  assign tx_accept  = core.send_resp && ((tx_state == S_IDLE) || tx_done);

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = (tx_cnt != '0) ? tx_cnt - CW'(1) : tx_cnt;
    tx_idx_nx   = tx_idx;
    tx_shift_nx = tx_shift;
    tx_nx       = tx_q;
    case (tx_state)
      S_IDLE: tx_nx = 1'b1;
      S_START: begin
        if (tx_bit_end) begin
          tx_state_nx = S_DATA;
          tx_cnt_nx   = BAUD_M1;
          tx_idx_nx   = 3'd0;
          tx_nx       = tx_shift[0];
        end
      end
      S_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_nx = BAUD_M1;
          if (tx_idx == 3'd7) begin
            tx_state_nx = S_STOP;
            tx_nx       = 1'b1;
          end else begin
            tx_idx_nx   = tx_idx + 3'd1;
            tx_shift_nx = {1'b0, tx_shift[7:1]};
            tx_nx       = tx_shift[1];
          end
        end
      end
      S_STOP: begin
        if (tx_bit_end) tx_state_nx = S_IDLE;
      end
      default: tx_state_nx = S_IDLE;
    endcase
    if (tx_accept) begin
      tx_state_nx = S_START;
      tx_cnt_nx   = BAUD_M1;
      tx_shift_nx = core.resp_data;
      tx_nx       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= 3'd0;
      tx_shift <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_idx   <= tx_idx_nx;
      tx_shift <= tx_shift_nx;
      tx_q     <= tx_nx;
    end
  end

  assign TX             = tx_q;
  assign core.resp_sent = tx_done;
  assign rx_state_dbg   = rx_state;
  assign tx_state_dbg   = tx_state;

endmodule
